// File: rtl/sram_2rw_pkg.sv
// Shared types and helpers for the two-port read/write SRAM controller.
package sram_2rw_pkg;

  localparam int unsigned MaxWidth = 512;
  localparam int unsigned IdxW     = $clog2(MaxWidth);
  localparam int unsigned RdLatMin = 1;
  localparam int unsigned RdLatMax = 2;

  typedef struct packed {
    logic [MaxWidth-1:0] rdata;
  } resp_entry_t;

  function automatic bit rd_lat_legal(int unsigned lat);
    return (lat >= RdLatMin) && (lat <= RdLatMax);
  endfunction

  // Lane i*gran..i*gran+gran-1 takes new_word when mask[i] is set, else keeps old_word.
  function automatic logic [MaxWidth-1:0] mask_merge(logic [MaxWidth-1:0] old_word,
                                                     logic [MaxWidth-1:0] new_word,
                                                     logic [MaxWidth-1:0] mask,
                                                     int unsigned         gran);
    logic [MaxWidth-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (mask[IdxW'(i / gran)]) res[IdxW'(i)] = new_word[IdxW'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_2rw_resp_q.sv
// Per-port read response pipeline: RD_LAT in-flight slots plus one holding slot, in order.
module sram_2rw_resp_q
  import sram_2rw_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        push_i,
  input  resp_entry_t push_data_i,
  input  logic        resp_ready_i,
  output logic        resp_valid_o,
  output resp_entry_t resp_data_o,
  output logic        rd_ok_o
);

  localparam int unsigned Cap    = RD_LAT + 1;
  localparam int unsigned CntW   = $clog2(Cap + 1);
  localparam logic [1:0]  LatAge = 2'(RD_LAT - 1);

  resp_entry_t           data_q [Cap];
  resp_entry_t           data_d [Cap];
  logic        [1:0]     age_q  [Cap];
  logic        [1:0]     age_d  [Cap];
  logic        [CntW-1:0] count_q, count_d;
  logic                  full, pop;

  assign full         = (count_q == CntW'(Cap));
  assign resp_valid_o = (count_q != '0) && (age_q[0] == 2'd0);
  assign pop          = resp_valid_o && resp_ready_i;
  // When full, the head has necessarily aged out, so a ready consumer frees a slot this cycle.
  assign rd_ok_o      = !full || resp_ready_i;
  assign resp_data_o  = resp_valid_o ? data_q[0] : '0;

  always_comb begin
    data_d  = data_q;
    age_d   = age_q;
    count_d = count_q;
    for (int i = 0; i < int'(Cap); i++) begin
      if (age_d[i] != 2'd0) age_d[i] = age_d[i] - 2'd1;
    end
    if (pop) begin
      for (int i = 0; i < int'(Cap) - 1; i++) begin
        data_d[i] = data_d[i+1];
        age_d[i]  = age_d[i+1];
      end
      count_d = count_d - CntW'(1);
    end
    if (push_i) begin
      for (int i = 0; i < int'(Cap); i++) begin
        if (CntW'(i) == count_d) begin
          data_d[i] = push_data_i;
          age_d[i]  = LatAge;
        end
      end
      count_d = count_d + CntW'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q <= '0;
      for (int i = 0; i < int'(Cap); i++) begin
        data_q[i] <= '0;
        age_q[i]  <= 2'd0;
      end
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: rtl/sram_2rw_ctrl.sv
// Two-port read/write SRAM with handshaked requests, byte-masked writes and per-port response
// backpressure. Define SRAM_2RW_BYPASS_EN to forward same-cycle writes to a colliding read.
module sram_2rw_ctrl
  import sram_2rw_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned MASK_GRAN = 8,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH),
  localparam int unsigned LANES    = WIDTH / MASK_GRAN
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              p0_req_valid_i,
  output logic              p0_req_ready_o,
  input  logic              p0_req_we_i,
  input  logic [ADDR_W-1:0] p0_req_addr_i,
  input  logic [WIDTH-1:0]  p0_req_wdata_i,
  input  logic [LANES-1:0]  p0_req_wmask_i,
  output logic              p0_resp_valid_o,
  input  logic              p0_resp_ready_i,
  output logic [WIDTH-1:0]  p0_resp_rdata_o,
  input  logic              p1_req_valid_i,
  output logic              p1_req_ready_o,
  input  logic              p1_req_we_i,
  input  logic [ADDR_W-1:0] p1_req_addr_i,
  input  logic [WIDTH-1:0]  p1_req_wdata_i,
  input  logic [LANES-1:0]  p1_req_wmask_i,
  output logic              p1_resp_valid_o,
  input  logic              p1_resp_ready_i,
  output logic [WIDTH-1:0]  p1_resp_rdata_o,
  output logic [15:0]       coll_count_o
);

  if (!rd_lat_legal(RD_LAT) || (WIDTH % MASK_GRAN) != 0 || WIDTH > MaxWidth ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("sram_2rw_ctrl: illegal parameter set");
  end

  function automatic logic [WIDTH-1:0] merge(logic [WIDTH-1:0] old_w, logic [WIDTH-1:0] new_w,
                                             logic [LANES-1:0] m);
    return WIDTH'(mask_merge(MaxWidth'(old_w), MaxWidth'(new_w), MaxWidth'(m), MASK_GRAN));
  endfunction

  logic [1:0]        req_valid, req_we, req_ready, resp_ready, resp_valid, rd_ok;
  logic [1:0]        fire, wr, rd;
  logic [ADDR_W-1:0] addr     [2];
  logic [WIDTH-1:0]  wdata    [2];
  logic [LANES-1:0]  wmask    [2];
  logic [WIDTH-1:0]  old_word [2];
  logic [WIDTH-1:0]  rd_word  [2];
  resp_entry_t       resp_data[2];
  logic [WIDTH-1:0]  mem_q    [DEPTH];
  logic              init_q, same_addr, coll;
  logic [15:0]       coll_q, coll_d;

  assign req_valid  = {p1_req_valid_i, p0_req_valid_i};
  assign req_we     = {p1_req_we_i, p0_req_we_i};
  assign resp_ready = {p1_resp_ready_i, p0_resp_ready_i};
  assign addr[0]    = p0_req_addr_i;
  assign addr[1]    = p1_req_addr_i;
  assign wdata[0]   = p0_req_wdata_i;
  assign wdata[1]   = p1_req_wdata_i;
  assign wmask[0]   = p0_req_wmask_i;
  assign wmask[1]   = p1_req_wmask_i;

  // Writes never wait on the read pipeline; reads stall only when it is full and stalled.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_ready[p] = init_q && !reset_i && (req_we[p] || rd_ok[p]);
      fire[p]      = req_valid[p] && req_ready[p];
      wr[p]        = fire[p] && req_we[p] && (|wmask[p]);
      rd[p]        = fire[p] && !req_we[p];
    end
  end

  assign old_word[0] = mem_q[addr[0]];
  assign old_word[1] = mem_q[addr[1]];
  assign same_addr   = (addr[0] == addr[1]);
  assign coll        = wr[0] && wr[1] && same_addr;
  assign coll_d      = (coll && coll_q != 16'hFFFF) ? coll_q + 16'd1 : coll_q;

  always_comb begin
    rd_word[0] = old_word[0];
    rd_word[1] = old_word[1];
`ifdef SRAM_2RW_BYPASS_EN
    if (wr[1] && same_addr) rd_word[0] = merge(old_word[0], wdata[1], wmask[1]);
    if (wr[0] && same_addr) rd_word[1] = merge(old_word[1], wdata[0], wmask[0]);
`endif
  end

  // Port 0 is merged last on a same-address collision so its lanes win.
  always_ff @(posedge clock_i) begin
    if (coll) begin
      mem_q[addr[0]] <= merge(merge(old_word[0], wdata[1], wmask[1]), wdata[0], wmask[0]);
    end else begin
      if (wr[0]) mem_q[addr[0]] <= merge(old_word[0], wdata[0], wmask[0]);
      if (wr[1]) mem_q[addr[1]] <= merge(old_word[1], wdata[1], wmask[1]);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      init_q <= 1'b0;
      coll_q <= 16'd0;
    end else begin
      init_q <= 1'b1;
      coll_q <= coll_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    sram_2rw_resp_q #(
      .RD_LAT(RD_LAT)
    ) u_resp_q (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .push_i      (rd[p]),
      .push_data_i ('{rdata: MaxWidth'(rd_word[p])}),
      .resp_ready_i(resp_ready[p]),
      .resp_valid_o(resp_valid[p]),
      .resp_data_o (resp_data[p]),
      .rd_ok_o     (rd_ok[p])
    );
  end

  assign p0_req_ready_o  = req_ready[0];
  assign p1_req_ready_o  = req_ready[1];
  assign p0_resp_valid_o = resp_valid[0];
  assign p1_resp_valid_o = resp_valid[1];
  assign p0_resp_rdata_o = resp_data[0].rdata[WIDTH-1:0];
  assign p1_resp_rdata_o = resp_data[1].rdata[WIDTH-1:0];
  assign coll_count_o    = coll_q;

endmodule

// File: tb/tb_sram_2rw_ctrl.sv
// Directed bench: RD_LAT=1 instance for data/collision behaviour, RD_LAT=2 for backpressure/reset.
module tb_sram_2rw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: RD_LAT = 1
  logic        a0_valid, a0_ready, a0_we, a0_rvalid, a0_rready;
  logic [6:0]  a0_addr;
  logic [31:0] a0_wdata, a0_rdata;
  logic [3:0]  a0_wmask;
  logic        a1_valid, a1_ready, a1_we, a1_rvalid, a1_rready;
  logic [6:0]  a1_addr;
  logic [31:0] a1_wdata, a1_rdata;
  logic [3:0]  a1_wmask;
  logic [15:0] a_coll;

  // Instance B: RD_LAT = 2
  logic        b0_valid, b0_ready, b0_we, b0_rvalid, b0_rready;
  logic [6:0]  b0_addr;
  logic [31:0] b0_wdata, b0_rdata;
  logic [3:0]  b0_wmask;
  logic        b1_valid, b1_ready, b1_we, b1_rvalid, b1_rready;
  logic [6:0]  b1_addr;
  logic [31:0] b1_wdata, b1_rdata;
  logic [3:0]  b1_wmask;
  logic [15:0] b_coll;

  sram_2rw_ctrl #(.RD_LAT(1)) u_dut_a (
    .clock_i(clk), .reset_i(rst),
    .p0_req_valid_i(a0_valid), .p0_req_ready_o(a0_ready), .p0_req_we_i(a0_we),
    .p0_req_addr_i(a0_addr), .p0_req_wdata_i(a0_wdata), .p0_req_wmask_i(a0_wmask),
    .p0_resp_valid_o(a0_rvalid), .p0_resp_ready_i(a0_rready), .p0_resp_rdata_o(a0_rdata),
    .p1_req_valid_i(a1_valid), .p1_req_ready_o(a1_ready), .p1_req_we_i(a1_we),
    .p1_req_addr_i(a1_addr), .p1_req_wdata_i(a1_wdata), .p1_req_wmask_i(a1_wmask),
    .p1_resp_valid_o(a1_rvalid), .p1_resp_ready_i(a1_rready), .p1_resp_rdata_o(a1_rdata),
    .coll_count_o(a_coll)
  );

  sram_2rw_ctrl #(.RD_LAT(2)) u_dut_b (
    .clock_i(clk), .reset_i(rst),
    .p0_req_valid_i(b0_valid), .p0_req_ready_o(b0_ready), .p0_req_we_i(b0_we),
    .p0_req_addr_i(b0_addr), .p0_req_wdata_i(b0_wdata), .p0_req_wmask_i(b0_wmask),
    .p0_resp_valid_o(b0_rvalid), .p0_resp_ready_i(b0_rready), .p0_resp_rdata_o(b0_rdata),
    .p1_req_valid_i(b1_valid), .p1_req_ready_o(b1_ready), .p1_req_we_i(b1_we),
    .p1_req_addr_i(b1_addr), .p1_req_wdata_i(b1_wdata), .p1_req_wmask_i(b1_wmask),
    .p1_resp_valid_o(b1_rvalid), .p1_resp_ready_i(b1_rready), .p1_resp_rdata_o(b1_rdata),
    .coll_count_o(b_coll)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a0(input logic v, input logic we, input logic [6:0] ad,
                        input logic [31:0] wd, input logic [3:0] m);
    a0_valid = v; a0_we = we; a0_addr = ad; a0_wdata = wd; a0_wmask = m;
  endtask

  task automatic set_a1(input logic v, input logic we, input logic [6:0] ad,
                        input logic [31:0] wd, input logic [3:0] m);
    a1_valid = v; a1_we = we; a1_addr = ad; a1_wdata = wd; a1_wmask = m;
  endtask

  task automatic set_b0(input logic v, input logic we, input logic [6:0] ad,
                        input logic [31:0] wd, input logic [3:0] m);
    b0_valid = v; b0_we = we; b0_addr = ad; b0_wdata = wd; b0_wmask = m;
  endtask

  logic [6:0]  rd_tbl [3];
  logic [31:0] rw_exp;
  int          acc;

  initial begin
    rd_tbl = '{7'd1, 7'd2, 7'd4};
    set_a0(0, 0, 0, 0, 0); set_a1(0, 0, 0, 0, 0);
    set_b0(0, 0, 0, 0, 0);
    b1_valid = 0; b1_we = 0; b1_addr = 0; b1_wdata = 0; b1_wmask = 0;
    a0_rready = 1; a1_rready = 1; b0_rready = 0; b1_rready = 1;

    // Reset behaviour
    tick(); tick();
    chk("ready_in_reset", {31'd0, a0_ready}, 32'd0);
    tick();
    rst = 0;
    chk("ready_just_after_reset", {31'd0, a1_ready}, 32'd0);
    chk("rvalid_reset", {31'd0, a0_rvalid}, 32'd0);
    chk("rdata_reset", a0_rdata, 32'd0);
    chk("coll_reset", {16'd0, a_coll}, 32'd0);
    tick();
    chk("ready_after_reset", {30'd0, a1_ready, a0_ready}, 32'd3);

    // Write/readback and partial-mask setup
    set_a0(1, 1, 7'd5, 32'hDEADBEEF, 4'hF);
    set_a1(1, 1, 7'd9, 32'h11223344, 4'hF);
    tick();
    set_a0(1, 1, 7'd9, 32'hAABBCCDD, 4'b0101);
    set_a1(1, 0, 7'd5, 32'd0, 4'h0);
    tick();
    chk("readback_valid", {31'd0, a1_rvalid}, 32'd1);
    chk("readback_data", a1_rdata, 32'hDEADBEEF);

    set_a0(0, 0, 0, 0, 0);
    set_a1(1, 0, 7'd9, 32'd0, 4'h0);
    tick();
    chk("partial_mask", a1_rdata, 32'h11BB33DD);

    // Write-write collision
    set_a0(1, 1, 7'd3, 32'hAAAAAAAA, 4'b0011);
    set_a1(1, 1, 7'd3, 32'h55555555, 4'b1111);
    tick();
    chk("coll_count_1", {16'd0, a_coll}, 32'd1);
    chk("write_no_resp", {31'd0, a1_rvalid}, 32'd0);

    set_a0(1, 0, 7'd3, 32'd0, 4'h0);
    set_a1(1, 1, 7'd7, 32'd0, 4'hF);
    tick();
    chk("ww_merge", a0_rdata, 32'h5555AAAA);

    // Read-write collision
    set_a0(1, 1, 7'd7, 32'hFFFFFFFF, 4'hF);
    set_a1(1, 0, 7'd7, 32'd0, 4'h0);
    tick();
`ifdef SRAM_2RW_BYPASS_EN
    rw_exp = 32'hFFFFFFFF;
`else
    rw_exp = 32'h00000000;
`endif
    chk("rw_collision", a1_rdata, rw_exp);

    // Read-read same address
    set_a0(1, 0, 7'd7, 32'd0, 4'h0);
    set_a1(1, 0, 7'd7, 32'd0, 4'h0);
    tick();
    chk("rr_p0", a0_rdata, 32'hFFFFFFFF);
    chk("rr_p1", a1_rdata, 32'hFFFFFFFF);

    // Zero-mask write on a same-address collision: no effect, not counted
    set_a0(1, 1, 7'd3, 32'h0, 4'h0);
    set_a1(1, 1, 7'd3, 32'h12345678, 4'hF);
    tick();
    chk("coll_zero_mask", {16'd0, a_coll}, 32'd1);
    set_a0(1, 0, 7'd3, 32'd0, 4'h0);
    set_a1(0, 0, 0, 0, 0);
    tick();
    chk("zero_mask_data", a0_rdata, 32'h12345678);
    set_a0(0, 0, 0, 0, 0);

    // Backpressure on RD_LAT=2 instance
    set_b0(1, 1, 7'd1, 32'h01010101, 4'hF); tick();
    set_b0(1, 1, 7'd2, 32'h02020202, 4'hF); tick();
    set_b0(1, 1, 7'd4, 32'h04040404, 4'hF); tick();
    acc = 0;
    set_b0(1, 0, rd_tbl[0], 32'd0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      if (b0_ready) acc++;
      tick();
      if (acc < 3) b0_addr = rd_tbl[acc];
    end
    chk("bp_accepted", acc, 32'd3);
    chk("bp_ready_low", {31'd0, b0_ready}, 32'd0);
    chk("bp_head_valid", {31'd0, b0_rvalid}, 32'd1);
    chk("bp_head_data", b0_rdata, 32'h01010101);
    tick();
    chk("bp_stable", b0_rdata, 32'h01010101);
    set_b0(0, 0, 0, 0, 0);
    b0_rready = 1;
    tick();
    chk("drain_2", b0_rdata, 32'h02020202);
    tick();
    chk("drain_3", b0_rdata, 32'h04040404);
    tick();
    chk("drain_empty", {31'd0, b0_rvalid}, 32'd0);

    // Reset with reads in flight
    set_b0(1, 0, 7'd2, 32'd0, 4'h0); tick();
    set_b0(1, 0, 7'd4, 32'd0, 4'h0); tick();
    set_b0(0, 0, 0, 0, 0);
    rst = 1;
    tick();
    chk("rst_flush_valid", {31'd0, b0_rvalid}, 32'd0);
    chk("rst_ready_low", {31'd0, b0_ready}, 32'd0);
    rst = 0;
    tick();
    chk("post_rst_ready", {31'd0, b0_ready}, 32'd1);
    chk("post_rst_no_valid", {31'd0, b0_rvalid}, 32'd0);
    tick();
    chk("post_rst_no_valid2", {31'd0, b0_rvalid}, 32'd0);
    set_b0(1, 0, 7'd4, 32'd0, 4'h0); tick();
    set_b0(0, 0, 0, 0, 0);
    chk("lat2_not_yet", {31'd0, b0_rvalid}, 32'd0);
    tick();
    chk("lat2_valid", {31'd0, b0_rvalid}, 32'd1);
    chk("post_rst_data", b0_rdata, 32'h04040404);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_2rw_ctrl.md
Name: sram_2rw_ctrl

Overview:
- Parametrised, synthesisable, single-clock two-port read/write SRAM with its own control logic; next generation of the fixed-size 2RW macro models.
- Each port has: valid/ready request handshake, write byte mask, configurable read latency, response backpressure via a per-port output holding register.
- Same-cycle address collisions are resolved deterministically.
- Sits between tile-side request logic and the memory array.

Parameters:
- WIDTH, 32, data bits per word; must be a multiple of MASK_GRAN.
- DEPTH, 128, number of words; power of two, 2 or more.
- MASK_GRAN, 8, bits covered by one write-mask bit.
- RD_LAT, 1, read latency in cycles from accept to response valid; legal values 1 or 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clock, in, 1, single clock for all logic.
- reset, in, 1, synchronous, active-high.
- p{0,1}_req_valid, in, 1, request present.
- p{0,1}_req_ready, out, 1, request accepted when valid && ready.
- p{0,1}_req_we, in, 1, 1 = write, 0 = read.
- p{0,1}_req_addr, in, ADDR_W, word address.
- p{0,1}_req_wdata, in, WIDTH, write data.
- p{0,1}_req_wmask, in, WIDTH/MASK_GRAN, per-lane write enable.
- p{0,1}_resp_valid, out, 1, read data valid.
- p{0,1}_resp_ready, in, 1, consumer accepts response.
- p{0,1}_resp_rdata, out, WIDTH, read data.
- coll_count, out, 16, saturating count of same-address write-write collisions.

Behaviour:
- Reset values: all resp_valid = 0; resp_rdata = 0; coll_count = 0; req_ready = 1 one cycle after reset deasserts (0 while reset is high).
- Memory contents are not reset. In simulation they are randomly initialised.
- Accept: a request fires on clock when valid && ready.
- Writes produce no response.
- Writes update only the lanes whose mask bit is 1. Mask of all zeros: the request is accepted, has no effect, and is not counted.
- Reads: resp_valid rises exactly RD_LAT cycles after accept if the response slot is free.
- Per-port pipeline holds up to RD_LAT in-flight reads plus one holding entry.
- req_ready = 0 when in-flight reads plus held entries equal RD_LAT+1 and resp_ready = 0.
- A write is never blocked by a full read pipeline. req_ready for writes depends only on reset. req_ready must not combinationally depend on req_valid.
- Responses on a port are returned in accept order. resp_rdata is stable while resp_valid && !resp_ready.
- Write-write, same address, same cycle:
  - Port 0 lanes win where both masks are set.
  - Port 1 lanes are applied where only port 1's mask is set.
  - coll_count increments by 1, saturating at 16'hFFFF.
- Read-write, same address, same cycle: the read returns the old data (read-before-write), unless BYPASS_EN is defined.
- Read of an address written in an earlier cycle returns the new data.
- Read-read, same address: both ports get identical data.
- Address wrap: addresses are in range by construction; no aliasing.
- Reset mid-operation: in-flight and held reads are discarded, and no resp_valid is issued after reset. Writes accepted before the reset edge have completed. The array keeps its contents.

Optional Feature:
- Macro: SRAM_2RW_BYPASS_EN.
- Defined: a read colliding same-cycle with a write to the same address on the other port returns the merged data:
  - written lanes carry the new data, with port 0 priority when both ports write;
  - unwritten lanes carry the old data.
- Not defined: read-before-write, i.e. the old word.

Decomposition:
- Package sram_2rw_pkg holds:
  - the mask-merge function (old, new, mask → word);
  - the RD_LAT legality check constant;
  - the response-entry struct {rdata}.
- One sub-module, sram_2rw_resp_q: per-port response pipeline with RD_LAT+1 entries, instantiated twice.

Test Plan:
- Write/readback: after reset, p0 writes addr 5 = 32'hDEADBEEF with mask 4'hF; p1 reads addr 5 the next cycle → with RD_LAT=1, p1_resp_rdata = 32'hDEADBEEF one cycle after accept.
- Partial mask: addr 9 holds 32'h11223344; p0 writes 32'hAABBCCDD with mask 4'b0101 → read of addr 9 returns 32'h11BB33DD.
- Write-write collision: p0 writes addr 3 = 32'hAAAAAAAA with mask 4'b0011; p1 writes addr 3 = 32'h55555555 with mask 4'b1111, same cycle → addr 3 = 32'h5555AAAA; coll_count = 1.
- Read-write collision: addr 7 holds 32'h0; same cycle, p0 writes 32'hFFFFFFFF and p1 reads addr 7 → p1 gets 32'h0 without the macro, 32'hFFFFFFFF with SRAM_2RW_BYPASS_EN.
- Backpressure: RD_LAT=2, p0_resp_ready = 0, p0 issues reads continuously → exactly 3 reads accepted, then req_ready = 0. Releasing resp_ready drains the 3 responses in order with stable data while stalled.
- Reset mid-flight: reset asserted for 1 cycle with 2 reads in flight → no resp_valid afterwards; a subsequent read returns the pre-reset written data.
